// File: rtl/local_ctrl_prefetch_full_if.sv
// Bus bundle for one ring tile: write stream, delay-read and prefetch token
// links, output packets and the external masked-write port.
interface local_ctrl_prefetch_full_if #(
    parameter int datawidth            = 16,
    parameter int address_vector_width = 8,
    parameter int sample_address_width = 8
);
    localparam int sample_width = 2 * datawidth;
    localparam int packet_width = sample_width + address_vector_width;

    logic [sample_width-1:0]         D;
    logic                            write_flag;
    logic                            input_write_boundary;
    logic                            write_boundary_next;

    logic                            from_glob_controller_valid;
    logic [sample_address_width-1:0] from_glob_controller_delay;
    logic [address_vector_width-1:0] from_glob_dest_addr;
    logic                            input_boundary_flag;
    logic [address_vector_width-1:0] prev_dest_address;
    logic                            boundary_next;
    logic [address_vector_width-1:0] dest_address;
    logic [packet_width-1:0]         packet_out;

    logic                            from_glob_prefetch_valid;
    logic [sample_address_width-1:0] from_glob_prefetch_start;
    logic [sample_address_width-1:0] from_glob_prefetch_stop;
    logic [address_vector_width-1:0] from_glob_prefetch_dest;
    logic                            input_prefetch_boundary_flag;
    logic [sample_address_width-1:0] prefetch_next_stop_address;
    logic [address_vector_width-1:0] prefetch_next_dest_addr;
    logic                            prefetch_boundary_prev;
    logic [sample_address_width-1:0] prefetch_stop_address;
    logic [address_vector_width-1:0] prefetch_dest_addr;
    logic [packet_width-1:0]         prefetch_packet_out;

    logic                            WEBM;
    logic [sample_width-1:0]         DM;
    logic [sample_width-1:0]         BWEBM;
    logic [sample_address_width-1:0] ext_sample_address_M;

    modport slave (
        input  D, write_flag, input_write_boundary,
        input  from_glob_controller_valid, from_glob_controller_delay, from_glob_dest_addr,
        input  input_boundary_flag, prev_dest_address,
        input  from_glob_prefetch_valid, from_glob_prefetch_start, from_glob_prefetch_stop,
        input  from_glob_prefetch_dest, input_prefetch_boundary_flag,
        input  prefetch_next_stop_address, prefetch_next_dest_addr,
        input  WEBM, DM, BWEBM, ext_sample_address_M,
        output write_boundary_next, boundary_next, dest_address, packet_out,
        output prefetch_boundary_prev, prefetch_stop_address, prefetch_dest_addr,
        output prefetch_packet_out
    );

    modport master (
        output D, write_flag, input_write_boundary,
        output from_glob_controller_valid, from_glob_controller_delay, from_glob_dest_addr,
        output input_boundary_flag, prev_dest_address,
        output from_glob_prefetch_valid, from_glob_prefetch_start, from_glob_prefetch_stop,
        output from_glob_prefetch_dest, input_prefetch_boundary_flag,
        output prefetch_next_stop_address, prefetch_next_dest_addr,
        output WEBM, DM, BWEBM, ext_sample_address_M,
        input  write_boundary_next, boundary_next, dest_address, packet_out,
        input  prefetch_boundary_prev, prefetch_stop_address, prefetch_dest_addr,
        input  prefetch_packet_out
    );
endinterface

// File: rtl/local_ctrl_prefetch_full.sv
// One ring tile: a sample bank with an independent streaming-write token,
// delay-read token (passed forward) and prefetch range token (passed backward).
module local_ctrl_prefetch_full #(
    parameter int N_sample             = 256,
    parameter int datawidth            = 16,
    parameter int address_vector_width = 8,
    parameter int sample_address_width = 8
) (
    input  logic                             CLK,
    input  logic                             reset,
    input  logic                             init,
    local_ctrl_prefetch_full_if.slave        bus
);
    localparam int sample_width = 2 * datawidth;
    localparam int packet_width = sample_width + address_vector_width;
    localparam logic [sample_address_width-1:0] last_addr = sample_address_width'(N_sample - 1);
    localparam logic [sample_address_width-1:0] one_addr  = sample_address_width'(1);

    function automatic logic [sample_width-1:0] merge_masked(
        input logic [sample_width-1:0] old_word,
        input logic [sample_width-1:0] new_word,
        input logic [sample_width-1:0] keep_mask
    );
        return (old_word & keep_mask) | (new_word & ~keep_mask);
    endfunction

    logic [sample_width-1:0] mem_r [N_sample];

    logic                            wr_active_r;
    logic [sample_address_width-1:0] wr_ptr_r;
    logic                            rd_active_r;
    logic [sample_address_width-1:0] rd_ptr_r;
    logic [address_vector_width-1:0] rd_dest_r;
    logic [packet_width-1:0]         packet_r;
    logic                            pf_active_r;
    logic [sample_address_width-1:0] pf_ptr_r;
    logic [sample_address_width-1:0] pf_stop_r;
    logic [address_vector_width-1:0] pf_dest_r;
    logic [packet_width-1:0]         pf_packet_r;

    logic wr_start_s;
    logic wr_last_s;
    logic rd_last_s;
    logic pf_at_stop_s;
    logic pf_wrap_s;

    assign wr_start_s   = bus.write_flag | bus.input_write_boundary;
    assign wr_last_s    = wr_active_r && (wr_ptr_r == last_addr);
    assign rd_last_s    = rd_active_r && (rd_ptr_r == last_addr);
    assign pf_at_stop_s = (pf_ptr_r == pf_stop_r);
    // Stop wins over the wrap: a range ending exactly at the top stays in this tile.
    assign pf_wrap_s    = pf_active_r && !pf_at_stop_s && (pf_ptr_r == last_addr);

    assign bus.write_boundary_next    = wr_last_s;
    assign bus.boundary_next          = rd_last_s;
    assign bus.dest_address           = rd_dest_r;
    assign bus.packet_out             = packet_r;
    assign bus.prefetch_boundary_prev = pf_wrap_s;
    assign bus.prefetch_stop_address  = pf_stop_r;
    assign bus.prefetch_dest_addr     = pf_dest_r;
    assign bus.prefetch_packet_out    = pf_packet_r;

    // Sample bank write port: the external masked write pre-empts the token write.
    always_ff @(posedge CLK) begin
        if (!bus.WEBM) begin
            mem_r[bus.ext_sample_address_M] <= merge_masked(mem_r[bus.ext_sample_address_M],
                                                            bus.DM, bus.BWEBM);
        end else if (wr_active_r) begin
            mem_r[wr_ptr_r] <= bus.D;
        end
    end

    // Write token: one sample per active cycle, hands off after the top address.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wr_active_r <= 1'b0;
            wr_ptr_r    <= '0;
        end else if (init) begin
            wr_active_r <= 1'b0;
            wr_ptr_r    <= '0;
        end else if (wr_start_s) begin
            wr_active_r <= 1'b1;
            wr_ptr_r    <= '0;
        end else if (wr_active_r) begin
            wr_active_r <= !wr_last_s;
            wr_ptr_r    <= wr_ptr_r + one_addr;
        end else begin
            wr_active_r <= 1'b0;
            wr_ptr_r    <= wr_ptr_r;
        end
    end

    // Delay-read token: global load has priority over the ring hand-off.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            rd_active_r <= 1'b0;
            rd_ptr_r    <= '0;
            rd_dest_r   <= '0;
            packet_r    <= '0;
        end else if (init) begin
            rd_active_r <= 1'b0;
            rd_ptr_r    <= '0;
            rd_dest_r   <= '0;
            packet_r    <= '0;
        end else begin
            packet_r <= rd_active_r ? {rd_dest_r, mem_r[rd_ptr_r]} : '0;
            if (bus.from_glob_controller_valid) begin
                rd_active_r <= 1'b1;
                rd_ptr_r    <= bus.from_glob_controller_delay;
                rd_dest_r   <= bus.from_glob_dest_addr;
            end else if (bus.input_boundary_flag) begin
                rd_active_r <= 1'b1;
                rd_ptr_r    <= '0;
                rd_dest_r   <= bus.prev_dest_address;
            end else if (rd_active_r) begin
                rd_active_r <= !rd_last_s;
                rd_ptr_r    <= rd_ptr_r + one_addr;
                rd_dest_r   <= rd_dest_r;
            end else begin
                rd_active_r <= 1'b0;
                rd_ptr_r    <= rd_ptr_r;
                rd_dest_r   <= rd_dest_r;
            end
        end
    end

    // Prefetch token: inclusive stop, otherwise spills into the previous tile at the top.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            pf_active_r <= 1'b0;
            pf_ptr_r    <= '0;
            pf_stop_r   <= '0;
            pf_dest_r   <= '0;
            pf_packet_r <= '0;
        end else if (init) begin
            pf_active_r <= 1'b0;
            pf_ptr_r    <= '0;
            pf_stop_r   <= '0;
            pf_dest_r   <= '0;
            pf_packet_r <= '0;
        end else begin
            pf_packet_r <= pf_active_r ? {pf_dest_r, mem_r[pf_ptr_r]} : '0;
            if (bus.from_glob_prefetch_valid) begin
                pf_active_r <= 1'b1;
                pf_ptr_r    <= bus.from_glob_prefetch_start;
                pf_stop_r   <= bus.from_glob_prefetch_stop;
                pf_dest_r   <= bus.from_glob_prefetch_dest;
            end else if (bus.input_prefetch_boundary_flag) begin
                pf_active_r <= 1'b1;
                pf_ptr_r    <= '0;
                pf_stop_r   <= bus.prefetch_next_stop_address;
                pf_dest_r   <= bus.prefetch_next_dest_addr;
            end else if (pf_active_r) begin
                pf_active_r <= !(pf_at_stop_s || (pf_ptr_r == last_addr));
                pf_ptr_r    <= (pf_at_stop_s || (pf_ptr_r == last_addr)) ? pf_ptr_r
                                                                        : pf_ptr_r + one_addr;
                pf_stop_r   <= pf_stop_r;
                pf_dest_r   <= pf_dest_r;
            end else begin
                pf_active_r <= 1'b0;
                pf_ptr_r    <= pf_ptr_r;
                pf_stop_r   <= pf_stop_r;
                pf_dest_r   <= pf_dest_r;
            end
        end
    end
endmodule

// File: tb/tb_local_ctrl_prefetch_full.sv
// Ring of four tiles driven with directed vectors; expected bank contents
// follow from the incrementing write stream.
module tb_local_ctrl_prefetch_full;
    localparam int NT = 4;

    logic CLK = 1'b0;
    logic reset;
    logic init;
    always #5 CLK = ~CLK;

    int checks_cnt = 0;
    int fail_cnt   = 0;

    logic [31:0] d_v, dm_v, bwebm_v;
    logic       write_flag [NT];
    logic       gv [NT];
    logic [7:0] gdelay [NT];
    logic [7:0] gdest [NT];
    logic       pv [NT];
    logic [7:0] pstart [NT];
    logic [7:0] pstop [NT];
    logic [7:0] pdest [NT];
    logic       webm [NT];
    logic [7:0] ext_addr [NT];

    logic        wbn [NT];
    logic        bn [NT];
    logic        pbp [NT];
    logic [7:0]  dest_o [NT];
    logic [7:0]  pstop_o [NT];
    logic [7:0]  pdest_o [NT];
    logic [39:0] pkt [NT];
    logic [39:0] ppkt [NT];

    local_ctrl_prefetch_full_if bus [NT] ();

    for (genvar g = 0; g < NT; g++) begin : tile
        localparam int nx = (g + 1) % NT;
        localparam int pr = (g + NT - 1) % NT;
        assign bus[g].D                            = d_v;
        assign bus[g].write_flag                   = write_flag[g];
        assign bus[g].input_write_boundary         = wbn[pr];
        assign bus[g].from_glob_controller_valid   = gv[g];
        assign bus[g].from_glob_controller_delay   = gdelay[g];
        assign bus[g].from_glob_dest_addr          = gdest[g];
        assign bus[g].input_boundary_flag          = bn[pr];
        assign bus[g].prev_dest_address            = dest_o[pr];
        assign bus[g].from_glob_prefetch_valid     = pv[g];
        assign bus[g].from_glob_prefetch_start     = pstart[g];
        assign bus[g].from_glob_prefetch_stop      = pstop[g];
        assign bus[g].from_glob_prefetch_dest      = pdest[g];
        assign bus[g].input_prefetch_boundary_flag = pbp[nx];
        assign bus[g].prefetch_next_stop_address   = pstop_o[nx];
        assign bus[g].prefetch_next_dest_addr      = pdest_o[nx];
        assign bus[g].WEBM                         = webm[g];
        assign bus[g].DM                           = dm_v;
        assign bus[g].BWEBM                        = bwebm_v;
        assign bus[g].ext_sample_address_M         = ext_addr[g];
        assign wbn[g]     = bus[g].write_boundary_next;
        assign bn[g]      = bus[g].boundary_next;
        assign pbp[g]     = bus[g].prefetch_boundary_prev;
        assign dest_o[g]  = bus[g].dest_address;
        assign pstop_o[g] = bus[g].prefetch_stop_address;
        assign pdest_o[g] = bus[g].prefetch_dest_addr;
        assign pkt[g]     = bus[g].packet_out;
        assign ppkt[g]    = bus[g].prefetch_packet_out;

        local_ctrl_prefetch_full dut (
            .CLK   (CLK),
            .reset (reset),
            .init  (init),
            .bus   (bus[g])
        );
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Bank contents after the 1024-cycle ring fill: tile t, address a.
    function automatic logic [31:0] fill_val(input int t, input int a);
        return 32'hFFFF_FFFF + 32'(256 * t + a);
    endfunction

    initial begin
        logic seen;
        reset = 1'b0;
        init  = 1'b0;
        d_v = 32'h0; dm_v = 32'h0; bwebm_v = 32'hFFFF_FFFF;
        for (int i = 0; i < NT; i++) begin
            write_flag[i] = 1'b0; gv[i] = 1'b0; gdelay[i] = 8'h00; gdest[i] = 8'h00;
            pv[i] = 1'b0; pstart[i] = 8'h00; pstop[i] = 8'h00; pdest[i] = 8'h00;
            webm[i] = 1'b1; ext_addr[i] = 8'h00;
        end
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check_val("reset_pkt0", 64'(pkt[0]), 64'h0);
        check_val("reset_dest2", 64'(dest_o[2]), 64'h0);

        // 1: reset in the middle of running tokens
        write_flag[0] = 1'b1;
        gv[1] = 1'b1; gdelay[1] = 8'h00; gdest[1] = 8'hAB;
        pv[2] = 1'b1; pstart[2] = 8'h00; pstop[2] = 8'h80; pdest[2] = 8'hCD;
        tick();
        write_flag[0] = 1'b0; gv[1] = 1'b0; pv[2] = 1'b0;
        repeat (2) tick();
        check_val("pre_rst_dest1", 64'(dest_o[1]), 64'hAB);
        check_val("pre_rst_pdest2", 64'(pdest_o[2]), 64'hCD);
        #2 reset = 1'b0;
        #1;
        check_val("rst_dest1", 64'(dest_o[1]), 64'h0);
        check_val("rst_pkt1", 64'(pkt[1]), 64'h0);
        check_val("rst_pdest2", 64'(pdest_o[2]), 64'h0);
        check_val("rst_pstop2", 64'(pstop_o[2]), 64'h0);
        check_val("rst_ppkt2", 64'(ppkt[2]), 64'h0);
        #1 reset = 1'b1;
        seen = 1'b0;
        repeat (300) begin
            tick();
            if (wbn[0] || bn[1] || (ppkt[2] != 40'h0)) seen = 1'b1;
        end
        check_val("no_token_after_rst", 64'(seen), 64'h0);

        // 2: stream write around the whole ring
        write_flag[0] = 1'b1;
        tick();
        write_flag[0] = 1'b0;
        for (int k = 0; k < 1024; k++) begin
            d_v = 32'hFFFF_FFFF + 32'(k);
            if (k == 254) check_val("wbn0_early", 64'(wbn[0]), 64'h0);
            if (k == 255) check_val("wbn0_pulse", 64'(wbn[0]), 64'h1);
            if (k == 255) check_val("wbn1_idle", 64'(wbn[1]), 64'h0);
            if (k == 256) check_val("wbn0_one_cycle", 64'(wbn[0]), 64'h0);
            if (k == 767) check_val("wbn2_pulse", 64'(wbn[2]), 64'h1);
            if (k == 1023) begin
                check_val("wbn3_pulse", 64'(wbn[3]), 64'h1);
                init = 1'b1;
            end
            tick();
        end
        init = 1'b0;
        check_val("init_wbn0", 64'(wbn[0]), 64'h0);

        // 3: delay-tap read on tile 2, hand-off to tile 3
        gv[2] = 1'b1; gdelay[2] = 8'h19; gdest[2] = 8'h08;
        tick();
        gv[2] = 1'b0;
        tick();
        for (int j = 0; j < 231; j++) begin
            check_val($sformatf("rd2_pkt_%0d", j), 64'(pkt[2]), 64'({8'h08, fill_val(2, 8'h19 + j)}));
            if (j == 229) check_val("bn2_pulse", 64'(bn[2]), 64'h1);
            if (j == 230) check_val("bn2_one_cycle", 64'(bn[2]), 64'h0);
            if (j == 230) check_val("dest2_held", 64'(dest_o[2]), 64'h08);
            tick();
        end
        check_val("rd3_addr0", 64'(pkt[3]), 64'({8'h08, fill_val(3, 0)}));
        check_val("rd2_idle", 64'(pkt[2]), 64'h0);
        tick();
        check_val("rd3_addr1", 64'(pkt[3]), 64'({8'h08, fill_val(3, 1)}));
        init = 1'b1;
        tick();
        init = 1'b0;
        check_val("init_pkt3", 64'(pkt[3]), 64'h0);

        // 4: prefetch inside tile 3
        pv[3] = 1'b1; pstart[3] = 8'h50; pstop[3] = 8'h60; pdest[3] = 8'h6F;
        tick();
        pv[3] = 1'b0;
        tick();
        for (int j = 0; j < 17; j++) begin
            check_val($sformatf("pf3_pkt_%0d", j), 64'(ppkt[3]), 64'({8'h6F, fill_val(3, 8'h50 + j)}));
            if (pbp[3]) check_val("pbp3_quiet", 64'(pbp[3]), 64'h0);
            tick();
        end
        check_val("pf3_done", 64'(ppkt[3]), 64'h0);
        check_val("pf3_stop_held", 64'(pstop_o[3]), 64'h60);
        check_val("pf2_untouched", 64'(ppkt[2]), 64'h0);

        // 5: prefetch wrapping from tile 1 into tile 0
        pv[1] = 1'b1; pstart[1] = 8'hF0; pstop[1] = 8'h10; pdest[1] = 8'h6F;
        tick();
        pv[1] = 1'b0;
        tick();
        for (int j = 0; j < 16; j++) begin
            check_val($sformatf("pf1_pkt_%0d", j), 64'(ppkt[1]), 64'({8'h6F, fill_val(1, 8'hF0 + j)}));
            if (j == 14) check_val("pbp1_pulse", 64'(pbp[1]), 64'h1);
            if (j == 15) check_val("pbp1_one_cycle", 64'(pbp[1]), 64'h0);
            tick();
        end
        for (int j = 0; j < 17; j++) begin
            check_val($sformatf("pf0_pkt_%0d", j), 64'(ppkt[0]), 64'({8'h6F, fill_val(0, j)}));
            tick();
        end
        check_val("pf0_done", 64'(ppkt[0]), 64'h0);
        check_val("pf0_stop", 64'(pstop_o[0]), 64'h10);
        check_val("pf0_dest", 64'(pdest_o[0]), 64'h6F);

        // 6: external masked write, verified by a delay read
        webm[0] = 1'b0; ext_addr[0] = 8'h05; dm_v = 32'h1234_5678; bwebm_v = 32'hFFFF_0000;
        tick();
        webm[0] = 1'b1; bwebm_v = 32'hFFFF_FFFF;
        gv[0] = 1'b1; gdelay[0] = 8'h05; gdest[0] = 8'h11;
        tick();
        gv[0] = 1'b0;
        tick();
        check_val("ext_masked_05", 64'(pkt[0]), 64'({8'h11, 32'h0000_5678}));
        tick();
        check_val("ext_neighbor_06", 64'(pkt[0]), 64'({8'h11, fill_val(0, 6)}));
        init = 1'b1;
        tick();
        init = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end
endmodule
